// File: rtl/waveform_burst_gen.sv
// waveform_burst_gen: multi-lane pulse-burst generator with programmable valid/zero phases and repeat count
module waveform_burst_gen #(
  parameter int SAMPLE_W  = 16,
  parameter int NUM_LANES = 12,
  parameter int DUR_W     = 32,
  parameter int CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_trigger,
  input  logic                          i_stop,
  input  logic [SAMPLE_W-1:0]           i_valid_amp,
  input  logic [SAMPLE_W-1:0]           i_zero_amp,
  input  logic [DUR_W-1:0]              i_data_duration,
  input  logic [DUR_W-1:0]              i_zero_duration,
  input  logic [CNT_W-1:0]              i_repeat,
  output logic [SAMPLE_W*NUM_LANES-1:0] o_data,
  output logic [NUM_LANES-1:0]          o_marker,
  output logic                          o_busy,
  output logic                          o_done
);
  localparam logic [1:0] IDLE = 2'd0, VALID = 2'd1, ZERO = 2'd2;
  localparam logic [DUR_W-1:0] NL = DUR_W'(NUM_LANES);
  logic [1:0] state;
  logic [DUR_W-1:0] rem, dd, zd, nrem;
  logic [SAMPLE_W-1:0] va, za;
  logic [CNT_W-1:0] rep, cnt;
  logic trig_q, start, stopping, wrap, last;
  logic [SAMPLE_W*NUM_LANES-1:0] word;
  logic [NUM_LANES-1:0] mark;
  function automatic logic [DUR_W-1:0] clamp(input logic [DUR_W-1:0] d);
    return d < NL ? NL : d;
  endfunction
  // Durations are clamped to at least one word, so a word holds at most one phase boundary.
  always_comb begin
    start = i_trigger && !trig_q && !i_stop && state == IDLE;
    stopping = state != IDLE && i_stop;
    wrap = rem <= NL;
    last = state == ZERO && rep != '0 && cnt + CNT_W'(1) == rep;
    nrem = wrap ? (state == VALID ? zd : dd) - (NL - rem) : rem - NL;
    word = '0;
    mark = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      mark[k] = state == VALID ? DUR_W'(k) < rem : state == ZERO && DUR_W'(k) >= rem && !last;
      word[k*SAMPLE_W +: SAMPLE_W] = mark[k] ? va : za;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rem <= '0;
      dd <= '0;
      zd <= '0;
      va <= '0;
      za <= '0;
      rep <= '0;
      cnt <= '0;
      trig_q <= 1'b0;
      o_data <= '0;
      o_marker <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      trig_q <= i_trigger;
      o_data <= stopping ? {NUM_LANES{za}} : word;
      o_marker <= stopping ? '0 : mark;
      o_busy <= state != IDLE && !i_stop;
      o_done <= !i_stop && last && wrap;
      if (start) begin
        va <= i_valid_amp;
        za <= i_zero_amp;
        dd <= clamp(i_data_duration);
        zd <= clamp(i_zero_duration);
        rep <= i_repeat;
        rem <= clamp(i_data_duration);
        cnt <= '0;
        state <= VALID;
      end else if (stopping) begin
        state <= IDLE;
      end else if (state != IDLE) begin
        rem <= nrem;
        if (wrap) begin
          state <= state == VALID ? ZERO : (last ? IDLE : VALID);
          if (state == ZERO) cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_waveform_burst_gen.sv
// tb_waveform_burst_gen: directed bench with a sample-stream reference model for waveform_burst_gen
module tb_waveform_burst_gen;
  localparam int N = 12;
  localparam int SW = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic i_trigger = 1'b0, i_stop = 1'b0;
  logic [SW-1:0] i_valid_amp = '0, i_zero_amp = '0;
  logic [31:0] i_data_duration = '0, i_zero_duration = '0;
  logic [15:0] i_repeat = '0;
  logic [SW*N-1:0] o_data;
  logic [N-1:0] o_marker;
  logic o_busy, o_done;
  int vectors = 0, errs = 0;

  waveform_burst_gen dut (
    .clk(clk), .rst(rst), .i_trigger(i_trigger), .i_stop(i_stop),
    .i_valid_amp(i_valid_amp), .i_zero_amp(i_zero_amp),
    .i_data_duration(i_data_duration), .i_zero_duration(i_zero_duration),
    .i_repeat(i_repeat), .o_data(o_data), .o_marker(o_marker),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [SW*N-1:0] act, input logic [SW*N-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: the burst is a sample stream; sample s is valid iff s mod period < dd and s < repeat*period.
  bit m_act = 0, m_tq = 0, tedge;
  longint m_dd = 0, m_zd = 0, m_rep = 0, m_w = 0, tot, s;
  logic [SW-1:0] m_va = '0, m_za = '0;
  logic [SW*N-1:0] e_data;
  logic [N-1:0] e_mark;
  logic e_busy, e_done;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_act = 0; m_tq = 0; m_za = '0; m_va = '0;
      end else begin
        tedge = i_trigger && !m_tq;
        m_tq = i_trigger;
        e_data = {N{m_za}}; e_mark = '0; e_busy = 0; e_done = 0;
        if (m_act) begin
          if (!i_stop) begin
            tot = m_rep * (m_dd + m_zd);
            for (int k = 0; k < N; k++) begin
              s = m_w * N + k;
              if (!(m_rep != 0 && s >= tot) && (s % (m_dd + m_zd)) < m_dd) begin
                e_mark[k] = 1'b1;
                e_data[k*SW +: SW] = m_va;
              end
            end
            e_busy = 1;
            e_done = m_rep != 0 && m_w == (tot - 1) / N;
            m_w++;
            if (e_done) m_act = 0;
          end else m_act = 0;
        end else if (tedge && !i_stop) begin
          m_va = i_valid_amp; m_za = i_zero_amp;
          m_dd = i_data_duration < N ? N : longint'(i_data_duration);
          m_zd = i_zero_duration < N ? N : longint'(i_zero_duration);
          m_rep = i_repeat; m_act = 1; m_w = 0;
        end
      end
      #1;
      if (!rst) begin
        chk("model data", o_data, e_data);
        chk("model marker", {{(SW*N-N){1'b0}}, o_marker}, {{(SW*N-N){1'b0}}, e_mark});
        chk("model busy", {{(SW*N-1){1'b0}}, o_busy}, {{(SW*N-1){1'b0}}, e_busy});
        chk("model done", {{(SW*N-1){1'b0}}, o_done}, {{(SW*N-1){1'b0}}, e_done});
      end
    end
  end

  task automatic cfg(input int dd, input int zd, input int rep);
    i_data_duration = dd; i_zero_duration = zd; i_repeat = 16'(rep);
  endtask

  initial begin
    logic [SW*N-1:0] w2;
    w2 = {{6{16'h0000}}, {6{16'h7FFF}}};
    i_valid_amp = 16'h7FFF;
    repeat (2) @(negedge clk);
    chk("reset data", o_data, '0);
    chk("reset marker", SW*N'(o_marker), '0);
    chk("reset busy", SW*N'(o_busy), '0);
    rst = 1'b0;
    @(negedge clk);
    cfg(24, 36, 1); i_trigger = 1;
    repeat (2) @(negedge clk);
    chk("t1 w0 marker", SW*N'(o_marker), SW*N'(12'hFFF));
    repeat (4) @(negedge clk);
    chk("t1 w4 done", SW*N'(o_done), SW*N'(1));
    chk("t1 w4 data", o_data, '0);
    @(negedge clk);
    chk("t1 idle busy", SW*N'(o_busy), '0);
    i_trigger = 0;
    @(negedge clk);
    cfg(30, 18, 2); i_trigger = 1;
    repeat (2) @(negedge clk);
    i_valid_amp = 16'h1111;
    repeat (2) @(negedge clk);
    chk("t2 w2 marker", SW*N'(o_marker), SW*N'(12'h03F));
    chk("t2 w2 data", o_data, w2);
    repeat (5) @(negedge clk);
    chk("t2 w7 done", SW*N'(o_done), SW*N'(1));
    i_trigger = 0; i_valid_amp = 16'h7FFF;
    @(negedge clk);
    cfg(5, 0, 1); i_trigger = 1;
    repeat (2) @(negedge clk);
    chk("t3 w0 marker", SW*N'(o_marker), SW*N'(12'hFFF));
    @(negedge clk);
    chk("t3 w1 marker", SW*N'(o_marker), '0);
    chk("t3 w1 done", SW*N'(o_done), SW*N'(1));
    i_trigger = 0;
    @(negedge clk);
    cfg(12, 12, 0); i_trigger = 1;
    repeat (2) @(negedge clk);
    chk("t4 w0 marker", SW*N'(o_marker), SW*N'(12'hFFF));
    i_trigger = 0;
    repeat (100) @(negedge clk);
    i_stop = 1;
    @(negedge clk);
    chk("t4 stop data", o_data, '0);
    chk("t4 stop busy", SW*N'(o_busy), '0);
    chk("t4 stop done", SW*N'(o_done), '0);
    i_trigger = 1;
    repeat (3) @(negedge clk);
    chk("t4 stop blocks start", SW*N'(o_busy), '0);
    i_trigger = 0; i_stop = 0;
    @(negedge clk);
    cfg(24, 36, 1); i_trigger = 1;
    repeat (15) @(negedge clk);
    chk("t5 held no restart", SW*N'(o_busy), '0);
    i_trigger = 0;
    @(negedge clk);
    i_trigger = 1;
    repeat (2) @(negedge clk);
    chk("t5 restart busy", SW*N'(o_busy), SW*N'(1));
    i_trigger = 0;
    @(negedge clk);
    i_trigger = 1;
    repeat (8) @(negedge clk);
    chk("t5 busy edge ignored", SW*N'(o_busy), '0);
    i_trigger = 0;
    @(negedge clk);
    cfg(12, 12, 0); i_zero_amp = 16'h0A0A; i_trigger = 1;
    repeat (5) @(negedge clk);
    #2 rst = 1; i_trigger = 0;
    #1;
    chk("t6 async data", o_data, '0);
    chk("t6 async marker", SW*N'(o_marker), '0);
    chk("t6 async busy", SW*N'(o_busy), '0);
    @(negedge clk);
    rst = 0; i_zero_amp = '0;
    @(negedge clk);
    i_trigger = 1;
    repeat (2) @(negedge clk);
    chk("t6 clean start marker", SW*N'(o_marker), SW*N'(12'hFFF));
    chk("t6 clean start busy", SW*N'(o_busy), SW*N'(1));
    i_trigger = 0; i_stop = 1;
    repeat (3) @(negedge clk);
    i_stop = 0;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
